// File: rtl/msd_readout_pkg.sv
// Shared types, FOOT constants and divider clamping for the MSD readout sequencer.
// Provides: seq_state_t, FOOT_* constants, clamp_div(), clamp_duty().
package msd_readout_pkg;

    localparam int FOOT_ADC_WIDTH = 16;
    localparam int FOOT_FE_CYCLES = 70;
    localparam int FOOT_N_ADC     = 10;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        SHIFT,
        RESET
    } seq_state_t;

    // A period below 2 cycles cannot have both a high and a low phase.
    function automatic logic [15:0] clamp_div(input logic [15:0] div);
        return (div < 16'd2) ? 16'd2 : div;
    endfunction

    // Keeps at least one high and one low cycle per period.
    function automatic logic [15:0] clamp_duty(
        input logic [15:0] duty,
        input logic [15:0] div_c
    );
        if (duty == 16'd0)
            return 16'd1;
        if (duty >= div_c)
            return div_c - 16'd1;
        return duty;
    endfunction

endpackage

// File: rtl/msd_adc_deserializer.sv
// Serial ADC front: generates CS/SCLK and shifts N_ADC lanes in parallel, MSB first.
// Ports: iCLK/iRST, i_start/o_busy/o_last handshake, i_div/i_duty (pre-clamped),
//        i_sdata lanes, o_cs (active-low), o_sclk, o_data words, o_valid strobe.
module msd_adc_deserializer
    import msd_readout_pkg::*;
#(
    parameter int ADC_WIDTH = FOOT_ADC_WIDTH,
    parameter int N_ADC     = FOOT_N_ADC
) (
    input  logic                       iCLK,
    input  logic                       iRST,
    input  logic                       i_start,
    input  logic [15:0]                i_div,
    input  logic [15:0]                i_duty,
    input  logic [N_ADC-1:0]           i_sdata,
    output logic                       o_busy,
    output logic                       o_last,
    output logic                       o_cs,
    output logic                       o_sclk,
    output logic [N_ADC*ADC_WIDTH-1:0] o_data,
    output logic                       o_valid
);
    localparam int BW = $clog2(ADC_WIDTH);

    logic                              r_busy;
    logic [16:0]                       r_ac;
    logic [BW-1:0]                     r_bit;
    logic                              r_cs;
    logic                              r_sclk;
    logic                              r_valid;
    logic [N_ADC-1:0][ADC_WIDTH-1:0]   r_sh;
    logic [N_ADC*ADC_WIDTH-1:0]        r_data;

    logic [N_ADC-1:0][ADC_WIDTH-1:0]   w_sh_nxt;
    logic [16:0]                       w_div_m1;
    logic [16:0]                       w_ac_inc;
    logic                              w_sample;

    assign w_div_m1 = {1'b0, i_div} - 17'd1;
    assign w_ac_inc = r_ac + 17'd1;
    // Bit is taken at the end of the low phase of each SCLK period.
    assign w_sample = r_busy && (r_ac == w_div_m1);
    assign o_last   = w_sample && (r_bit == BW'(ADC_WIDTH - 1));

    always_comb begin
        w_sh_nxt = '0;
        for (int k = 0; k < N_ADC; k++)
            w_sh_nxt[k] = {r_sh[k][ADC_WIDTH-2:0], i_sdata[k]};
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_busy  <= 1'b0;
            r_ac    <= '0;
            r_bit   <= '0;
            r_cs    <= 1'b1;
            r_sclk  <= 1'b0;
            r_valid <= 1'b0;
            r_sh    <= '0;
            r_data  <= '0;
        end else begin
            r_valid <= 1'b0;
            if (!r_busy) begin
                if (i_start) begin
                    r_busy <= 1'b1;
                    r_ac   <= '0;
                    r_bit  <= '0;
                    r_cs   <= 1'b0;
                    r_sclk <= 1'b1;
                end
            end else if (w_sample) begin
                r_sh <= w_sh_nxt;
                r_ac <= '0;
                if (o_last) begin
                    r_busy  <= 1'b0;
                    r_cs    <= 1'b1;
                    r_sclk  <= 1'b0;
                    r_data  <= w_sh_nxt;
                    r_valid <= 1'b1;
                end else begin
                    r_bit  <= r_bit + BW'(1);
                    r_sclk <= 1'b1;
                end
            end else begin
                r_ac   <= w_ac_inc;
                r_sclk <= (w_ac_inc < {1'b0, i_duty});
            end
        end
    end

    assign o_busy  = r_busy;
    assign o_cs    = r_cs;
    assign o_sclk  = r_sclk;
    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/msd_readout_sequencer.sv
// FOOT MSD readout sequencer: trigger generation, config latch, FE sequencing FSM.
// Ports: iCLK/iRST, clock divider/duty config, iCFG_FE, iINT_TRIG_PER, iEXT_TRIG,
//        iADC_SDATA lanes; FE hold/clk/dreset/cfg, ADC cs/sclk, data/valid, busy, lost count.
module msd_readout_sequencer
    import msd_readout_pkg::*;
#(
    parameter int ADC_WIDTH = FOOT_ADC_WIDTH,
    parameter int FE_CYCLES = FOOT_FE_CYCLES,
    parameter int N_ADC     = FOOT_N_ADC
) (
    input  logic                       iCLK,
    input  logic                       iRST,
    input  logic [15:0]                iADC_CLK_DIV,
    input  logic [15:0]                iADC_CLK_DUTY,
    input  logic [15:0]                iFE_CLK_DIV,
    input  logic [15:0]                iFE_CLK_DUTY,
    input  logic [3:0]                 iCFG_FE,
    input  logic [31:0]                iINT_TRIG_PER,
    input  logic                       iEXT_TRIG,
    input  logic [N_ADC-1:0]           iADC_SDATA,
    output logic                       oFE_HOLD,
    output logic                       oFE_CLK,
    output logic                       oFE_DRESET,
    output logic [3:0]                 oFE_CFG,
    output logic                       oADC_CS,
    output logic                       oADC_SCLK,
    output logic [N_ADC*ADC_WIDTH-1:0] oDATA,
    output logic                       oDATA_VALID,
    output logic                       oBUSY,
    output logic [15:0]                oTRIG_LOST
);
    localparam int PCW = $clog2(FE_CYCLES);

    seq_state_t     r_state;
    seq_state_t     w_state_nxt;
    logic [16:0]    r_fc;
    logic [16:0]    w_fc_nxt;
    logic [PCW-1:0] r_pc;
    logic [PCW-1:0] w_pc_nxt;
    logic           r_started;
    logic           w_started_nxt;

    logic [31:0]    r_int_cnt;
    logic [15:0]    r_fe_div;
    logic [15:0]    r_fe_duty;
    logic [15:0]    r_adc_div;
    logic [15:0]    r_adc_duty;
    logic [3:0]     r_cfg;
    logic           r_fe_hold;
    logic           r_fe_clk;
    logic           r_fe_dreset;
    logic           r_busy;
    logic [15:0]    r_lost;

    logic [15:0]    w_fe_div_c;
    logic [15:0]    w_adc_div_c;
    logic [16:0]    w_fe_div_m1;
    logic           w_int_pulse;
    logic           w_trig;
    logic           w_accept;
    logic           w_fc_end;
    logic           w_start;
    logic           w_ser_free;
    logic           w_adc_busy;
    logic           w_adc_last;

    assign w_fe_div_c  = clamp_div(iFE_CLK_DIV);
    assign w_adc_div_c = clamp_div(iADC_CLK_DIV);

    // >= so that shrinking the period below the current count still wraps.
    assign w_int_pulse = (iINT_TRIG_PER != 32'd0) &&
                         (r_int_cnt >= iINT_TRIG_PER - 32'd1);
    assign w_trig      = iEXT_TRIG | w_int_pulse;
    assign w_accept    = w_trig && (r_state == IDLE);

    assign w_fe_div_m1 = {1'b0, r_fe_div} - 17'd1;
    assign w_fc_end    = (r_fc == w_fe_div_m1);
    assign w_start     = (r_state == SHIFT) && !r_started &&
                         (r_fc == {1'b0, r_fe_duty});
    // The deserializer counts as free in its final sampling cycle.
    assign w_ser_free  = !w_adc_busy || w_adc_last;

    always_comb begin
        w_state_nxt   = r_state;
        w_fc_nxt      = r_fc;
        w_pc_nxt      = r_pc;
        w_started_nxt = r_started;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = HOLD;
                    w_fc_nxt    = '0;
                end
            end
            HOLD: begin
                if (w_fc_end) begin
                    w_state_nxt   = SHIFT;
                    w_fc_nxt      = '0;
                    w_pc_nxt      = '0;
                    w_started_nxt = 1'b0;
                end else begin
                    w_fc_nxt = r_fc + 17'd1;
                end
            end
            SHIFT: begin
                if (w_start)
                    w_started_nxt = 1'b1;
                if (w_fc_end) begin
                    // Stall the FE period until this channel's word is in.
                    if (r_started && w_ser_free) begin
                        w_fc_nxt      = '0;
                        w_started_nxt = 1'b0;
                        if (r_pc == PCW'(FE_CYCLES - 1))
                            w_state_nxt = RESET;
                        else
                            w_pc_nxt = r_pc + PCW'(1);
                    end
                end else begin
                    w_fc_nxt = r_fc + 17'd1;
                end
            end
            RESET: begin
                if (w_fc_end) begin
                    w_state_nxt = IDLE;
                    w_fc_nxt    = '0;
                end else begin
                    w_fc_nxt = r_fc + 17'd1;
                end
            end
        endcase
    end

    // FE outputs are decoded from next-state values so they are registered
    // yet line up with the state they belong to.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state     <= IDLE;
            r_fc        <= '0;
            r_pc        <= '0;
            r_started   <= 1'b0;
            r_busy      <= 1'b0;
            r_fe_hold   <= 1'b0;
            r_fe_dreset <= 1'b0;
            r_fe_clk    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fc        <= w_fc_nxt;
            r_pc        <= w_pc_nxt;
            r_started   <= w_started_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_fe_hold   <= (w_state_nxt == HOLD) || (w_state_nxt == SHIFT);
            r_fe_dreset <= (w_state_nxt == RESET);
            r_fe_clk    <= (w_state_nxt == SHIFT) &&
                           (w_fc_nxt < {1'b0, r_fe_duty});
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_int_cnt  <= '0;
            r_fe_div   <= 16'd2;
            r_fe_duty  <= 16'd1;
            r_adc_div  <= 16'd2;
            r_adc_duty <= 16'd1;
            r_cfg      <= '0;
            r_lost     <= '0;
        end else begin
            if (iINT_TRIG_PER == 32'd0 || w_int_pulse)
                r_int_cnt <= '0;
            else
                r_int_cnt <= r_int_cnt + 32'd1;

            if (w_accept) begin
                r_fe_div   <= w_fe_div_c;
                r_fe_duty  <= clamp_duty(iFE_CLK_DUTY, w_fe_div_c);
                r_adc_div  <= w_adc_div_c;
                r_adc_duty <= clamp_duty(iADC_CLK_DUTY, w_adc_div_c);
                r_cfg      <= iCFG_FE;
            end

            if (w_trig && (r_state != IDLE) && (r_lost != 16'hFFFF))
                r_lost <= r_lost + 16'd1;
        end
    end

    msd_adc_deserializer #(
        .ADC_WIDTH (ADC_WIDTH),
        .N_ADC     (N_ADC)
    ) u_adc (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .i_start (w_start),
        .i_div   (r_adc_div),
        .i_duty  (r_adc_duty),
        .i_sdata (iADC_SDATA),
        .o_busy  (w_adc_busy),
        .o_last  (w_adc_last),
        .o_cs    (oADC_CS),
        .o_sclk  (oADC_SCLK),
        .o_data  (oDATA),
        .o_valid (oDATA_VALID)
    );

    assign oFE_HOLD   = r_fe_hold;
    assign oFE_CLK    = r_fe_clk;
    assign oFE_DRESET = r_fe_dreset;
    assign oFE_CFG    = r_cfg;
    assign oBUSY      = r_busy;
    assign oTRIG_LOST = r_lost;

endmodule

// File: tb/tb_msd_readout_sequencer.sv
// Self-checking bench for msd_readout_sequencer: vector table, random events,
// internal-trigger model and reset corner cases against a serial-ADC model.
module tb_msd_readout_sequencer;
    localparam int W     = 16;
    localparam int NCH   = 70;
    localparam int NA    = 10;
    localparam int BOUND = 20000;

    logic              clk = 1'b0;
    logic              iRST = 1'b0;
    logic [15:0]       iADC_CLK_DIV = 16'd2;
    logic [15:0]       iADC_CLK_DUTY = 16'd1;
    logic [15:0]       iFE_CLK_DIV = 16'd2;
    logic [15:0]       iFE_CLK_DUTY = 16'd1;
    logic [3:0]        iCFG_FE = '0;
    logic [31:0]       iINT_TRIG_PER = '0;
    logic              iEXT_TRIG = 1'b0;
    logic [NA-1:0]     iADC_SDATA = '0;
    logic              oFE_HOLD, oFE_CLK, oFE_DRESET;
    logic [3:0]        oFE_CFG;
    logic              oADC_CS, oADC_SCLK;
    logic [NA*W-1:0]   oDATA;
    logic              oDATA_VALID, oBUSY;
    logic [15:0]       oTRIG_LOST;

    always #5 clk = ~clk;

    msd_readout_sequencer dut (
        .iCLK(clk), .iRST(iRST),
        .iADC_CLK_DIV(iADC_CLK_DIV), .iADC_CLK_DUTY(iADC_CLK_DUTY),
        .iFE_CLK_DIV(iFE_CLK_DIV), .iFE_CLK_DUTY(iFE_CLK_DUTY),
        .iCFG_FE(iCFG_FE), .iINT_TRIG_PER(iINT_TRIG_PER),
        .iEXT_TRIG(iEXT_TRIG), .iADC_SDATA(iADC_SDATA),
        .oFE_HOLD(oFE_HOLD), .oFE_CLK(oFE_CLK), .oFE_DRESET(oFE_DRESET),
        .oFE_CFG(oFE_CFG), .oADC_CS(oADC_CS), .oADC_SCLK(oADC_SCLK),
        .oDATA(oDATA), .oDATA_VALID(oDATA_VALID), .oBUSY(oBUSY),
        .oTRIG_LOST(oTRIG_LOST)
    );

    int checks = 0;
    int errors = 0;
    int exp_lost = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- ADC model and monitor ----------------
    bit                  pat_fixed = 1'b1;
    logic [W-1:0]        pat = 16'hA5C3;
    logic [NA-1:0][W-1:0] words;
    logic [NA*W-1:0]     expq[$];
    int idx = -1;
    int strobes = 0, fe_high = 0, fe_rises = 0, sclk_high = 0, sclk_rises = 0;
    int hold_cnt = 0, dres = 0, ev_cnt = 0;
    logic p_cs = 1'b1, p_sclk = 1'b0, p_fe = 1'b0, p_busy = 1'b0;

    always @(posedge clk) begin
        logic [NA*W-1:0] e;
        #1;
        if (oADC_CS) begin
            idx = -1;
        end else if (p_cs) begin
            for (int k = 0; k < NA; k++)
                words[k] = pat_fixed ? pat : 16'($urandom);
            expq.push_back(words);
        end
        if (!oADC_CS && oADC_SCLK && !p_sclk) begin
            idx++;
            sclk_rises++;
        end
        if (oADC_SCLK) sclk_high++;
        for (int k = 0; k < NA; k++)
            iADC_SDATA[k] = (!oADC_CS && idx >= 0 && idx < W) ?
                            words[k][W-1-idx] : 1'($urandom);
        if (oDATA_VALID) begin
            strobes++;
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL strobe: unexpected word %h", oDATA);
            end else begin
                e = expq.pop_front();
                if (oDATA !== e) begin
                    errors++;
                    $display("FAIL data: got %h expected %h", oDATA, e);
                end
            end
        end
        if (oFE_CLK) fe_high++;
        if (oFE_CLK && !p_fe) fe_rises++;
        if (oFE_HOLD && fe_rises == 0 && !oFE_CLK) hold_cnt++;
        if (oFE_DRESET) dres++;
        if (oBUSY && !p_busy) ev_cnt++;
        p_cs = oADC_CS;
        p_sclk = oADC_SCLK;
        p_fe = oFE_CLK;
        p_busy = oBUSY;
    end

    // ---------------- reference helpers ----------------
    function automatic int ref_div(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    function automatic int ref_duty(input int du, input int dv);
        if (du == 0) return 1;
        if (du >= dv) return dv - 1;
        return du;
    endfunction

    task automatic chk_rst(input string nm);
        chk({nm, ".hold"}, 64'(oFE_HOLD), 0);
        chk({nm, ".feclk"}, 64'(oFE_CLK), 0);
        chk({nm, ".dreset"}, 64'(oFE_DRESET), 0);
        chk({nm, ".cfg"}, 64'(oFE_CFG), 0);
        chk({nm, ".cs"}, 64'(oADC_CS), 1);
        chk({nm, ".sclk"}, 64'(oADC_SCLK), 0);
        chk({nm, ".data0"}, 64'(oDATA == '0), 1);
        chk({nm, ".valid"}, 64'(oDATA_VALID), 0);
        chk({nm, ".busy"}, 64'(oBUSY), 0);
        chk({nm, ".lost"}, 64'(oTRIG_LOST), 0);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        iRST = 1'b1;
        strobes = 0;
        repeat (3) @(negedge clk);
        chk_rst(nm);
        chk({nm, ".nostrobe"}, 64'(strobes), 0);
        iRST = 1'b0;
        exp_lost = 0;
        expq.delete();
    endtask

    task automatic set_cfg(input int fd, input int fdu, input int ad, input int adu,
                           input logic [3:0] cfg);
        iFE_CLK_DIV = 16'(fd);
        iFE_CLK_DUTY = 16'(fdu);
        iADC_CLK_DIV = 16'(ad);
        iADC_CLK_DUTY = 16'(adu);
        iCFG_FE = cfg;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (oBUSY && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        chk({nm, ".done"}, 64'(oBUSY), 0);
    endtask

    task automatic run_event(input int fd, input int fdu, input int ad, input int adu,
                             input logic [3:0] cfg, input int e_duty, input int e_div,
                             input int e_aduty, input string nm);
        set_cfg(fd, fdu, ad, adu, cfg);
        @(negedge clk);
        strobes = 0; fe_high = 0; fe_rises = 0; sclk_high = 0;
        sclk_rises = 0; hold_cnt = 0; dres = 0;
        iEXT_TRIG = 1'b1;
        @(negedge clk);
        iEXT_TRIG = 1'b0;
        // Scramble inputs: the event must run on the latched copy.
        set_cfg(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), ~cfg);
        chk({nm, ".busy"}, 64'(oBUSY), 1);
        repeat (10) @(negedge clk);
        chk({nm, ".cfg"}, 64'(oFE_CFG), 64'(cfg));
        iEXT_TRIG = 1'b1;
        @(negedge clk);
        iEXT_TRIG = 1'b0;
        exp_lost++;
        wait_idle(nm);
        chk({nm, ".strobes"}, 64'(strobes), NCH);
        chk({nm, ".ferises"}, 64'(fe_rises), NCH);
        chk({nm, ".fehigh"}, 64'(fe_high), 64'(NCH * e_duty));
        chk({nm, ".holdlen"}, 64'(hold_cnt), 64'(e_div));
        chk({nm, ".dreslen"}, 64'(dres), 64'(e_div));
        chk({nm, ".sclkrises"}, 64'(sclk_rises), NCH * W);
        chk({nm, ".sclkhigh"}, 64'(sclk_high), 64'(NCH * W * e_aduty));
        chk({nm, ".lost"}, 64'(oTRIG_LOST), 64'(exp_lost));
        chk({nm, ".cs"}, 64'(oADC_CS), 1);
        chk({nm, ".qempty"}, 64'(expq.size()), 0);
    endtask

    // Pulses every per cycles; an accepted pulse makes the block busy for evlen.
    task automatic int_test(input int per, input int ncyc, input string nm);
        int acc = 0, lost = 0, busy_until = 0;
        do_reset({nm, ".rst"});
        set_cfg(40, 7, 2, 1, 4'h6);
        pat_fixed = 1'b0;
        ev_cnt = 0;
        strobes = 0;
        @(negedge clk);
        iINT_TRIG_PER = 32'(per);
        repeat (ncyc) @(negedge clk);
        iINT_TRIG_PER = '0;
        wait_idle(nm);
        for (int t = per; t <= ncyc; t += per) begin
            if (t >= busy_until) begin
                acc++;
                busy_until = t + 2 + 2 * 40 + NCH * 40;
            end else begin
                lost++;
            end
        end
        chk({nm, ".events"}, 64'(ev_cnt), 64'(acc));
        chk({nm, ".lost"}, 64'(oTRIG_LOST), 64'(lost));
        chk({nm, ".strobes"}, 64'(strobes), 64'(acc * NCH));
    endtask

    typedef struct {
        int fd, fdu, ad, adu;
        logic [3:0] cfg;
        bit fixed;
        logic [15:0] pat;
        int e_duty, e_div, e_aduty;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int n;
        int fd, fdu, ad, adu;
        tbl[0] = '{40, 7, 2, 1, 4'h5, 1'b1, 16'hA5C3, 7, 40, 1};
        tbl[1] = '{10, 3, 4, 2, 4'hA, 1'b0, 16'h0000, 3, 10, 2};
        tbl[2] = '{0, 4, 0, 4, 4'h3, 1'b1, 16'h5A3C, 1, 2, 1};
        tbl[3] = '{5, 9, 3, 0, 4'hF, 1'b0, 16'h0000, 4, 5, 1};
        tbl[4] = '{1, 0, 3, 3, 4'h9, 1'b1, 16'hFFFF, 1, 2, 2};

        do_reset("reset");

        for (int i = 0; i < 5; i++) begin
            pat_fixed = tbl[i].fixed;
            pat = tbl[i].pat;
            run_event(tbl[i].fd, tbl[i].fdu, tbl[i].ad, tbl[i].adu, tbl[i].cfg,
                      tbl[i].e_duty, tbl[i].e_div, tbl[i].e_aduty,
                      $sformatf("vec%0d", i));
        end

        pat_fixed = 1'b0;
        for (int r = 0; r < 4; r++) begin
            fd = int'($urandom_range(0, 40));
            fdu = int'($urandom_range(0, 45));
            ad = int'($urandom_range(0, 3));
            adu = int'($urandom_range(0, 4));
            run_event(fd, fdu, ad, adu, 4'($urandom),
                      ref_duty(fdu, ref_div(fd)), ref_div(fd),
                      ref_duty(adu, ref_div(ad)), $sformatf("rnd%0d", r));
        end

        int_test(4000, 14000, "intA");
        int_test(1000, 9500, "intB");

        do_reset("mid.rst");
        set_cfg(40, 7, 2, 1, 4'hC);
        pat_fixed = 1'b1;
        pat = 16'h3C96;
        strobes = 0;
        @(negedge clk);
        iEXT_TRIG = 1'b1;
        @(negedge clk);
        iEXT_TRIG = 1'b0;
        n = 0;
        while (strobes < 5 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        chk("mid.five", 64'(strobes), 5);
        iRST = 1'b1;
        @(negedge clk);
        chk_rst("mid");
        iRST = 1'b0;
        expq.delete();
        exp_lost = 0;
        run_event(40, 7, 2, 1, 4'hC, 7, 40, 1, "after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
